// File: rtl/fft32_out_streamer.sv
// Streams one captured FFT32 frame out bin-by-bin over a valid/ready port.
// It also tracks the peak |re|+|im| bin and flags done edges that arrive while a frame is still in flight.
module fft32_out_streamer #(
    parameter int WORD_SIZE = 16,
    parameter int FRACTION  = 8
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_fft_done,
    input  logic [32*WORD_SIZE-1:0]   i_re_bus,
    input  logic [32*WORD_SIZE-1:0]   i_im_bus,
    input  logic                      i_bin_ready,
    output logic                      o_bin_valid,
    output logic [4:0]                o_bin_idx,
    output logic [WORD_SIZE-1:0]      o_bin_re,
    output logic [WORD_SIZE-1:0]      o_bin_im,
    output logic [WORD_SIZE:0]        o_bin_mag,
    output logic                      o_last,
    output logic                      o_busy,
    output logic                      o_peak_valid,
    output logic [4:0]                o_peak_idx,
    output logic [WORD_SIZE:0]        o_peak_mag,
    output logic                      o_overrun,
    output logic [1:0]                o_state_dbg
);

    // FRACTION only labels the fixed-point format; the datapath never shifts by it.
    if (FRACTION < 0 || FRACTION >= WORD_SIZE) begin : g_bad_fraction
        $error("FRACTION must lie in [0, WORD_SIZE)");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        REPORT = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [4:0]             idx_q, idx_d;
    logic                   done_q;
    logic [4:0]             peak_idx_q, peak_idx_d;
    logic [WORD_SIZE:0]     peak_mag_q, peak_mag_d;
    logic                   peak_valid_q, peak_valid_d;
    logic                   overrun_q, overrun_d;

    logic [WORD_SIZE-1:0]   re_buf_q [32];
    logic [WORD_SIZE-1:0]   im_buf_q [32];

    logic                   done_edge;
    logic                   capture;
    logic                   xfer;
    logic [WORD_SIZE-1:0]   sel_re;
    logic [WORD_SIZE-1:0]   sel_im;
    logic [WORD_SIZE:0]     re_ext;
    logic [WORD_SIZE:0]     im_ext;
    logic [WORD_SIZE:0]     abs_re;
    logic [WORD_SIZE:0]     abs_im;
    logic [WORD_SIZE:0]     mag;

    assign done_edge = i_fft_done && !done_q;

    // Handshake: a bin moves when o_bin_valid && i_bin_ready at a rising clock;
    // while valid is high and ready low, every o_bin_* and o_last holds its value.
    assign o_bin_valid = (state_q == STREAM);
    assign xfer        = o_bin_valid && i_bin_ready;

    // Data outputs are forced to zero whenever no bin is presented, so reset clears them at once.
    assign sel_re = o_bin_valid ? re_buf_q[idx_q] : '0;
    assign sel_im = o_bin_valid ? im_buf_q[idx_q] : '0;

    // One extra bit keeps |most-negative| representable without saturation.
    assign re_ext = {sel_re[WORD_SIZE-1], sel_re};
    assign im_ext = {sel_im[WORD_SIZE-1], sel_im};
    assign abs_re = re_ext[WORD_SIZE] ? (~re_ext + 1'b1) : re_ext;
    assign abs_im = im_ext[WORD_SIZE] ? (~im_ext + 1'b1) : im_ext;
    assign mag    = abs_re + abs_im;

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        peak_idx_d   = peak_idx_q;
        peak_mag_d   = peak_mag_q;
        peak_valid_d = peak_valid_q;
        overrun_d    = 1'b0;
        capture      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (done_edge) begin
                    capture      = 1'b1;
                    state_d      = STREAM;
                    idx_d        = 5'd0;
                    peak_idx_d   = 5'd0;
                    peak_mag_d   = '0;
                    peak_valid_d = 1'b0;
                end
            end
            STREAM: begin
                overrun_d = done_edge;
                if (xfer) begin
                    // Strict compare keeps the lowest index on ties.
                    if (mag > peak_mag_q) begin
                        peak_idx_d = idx_q;
                        peak_mag_d = mag;
                    end
                    if (idx_q == 5'd31) begin
                        state_d      = REPORT;
                        peak_valid_d = 1'b1;
                    end else begin
                        idx_d = idx_q + 5'd1;
                    end
                end
            end
            REPORT: begin
                overrun_d = done_edge;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q      <= IDLE;
            idx_q        <= 5'd0;
            done_q       <= 1'b0;
            peak_idx_q   <= 5'd0;
            peak_mag_q   <= '0;
            peak_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            done_q       <= i_fft_done;
            peak_idx_q   <= peak_idx_d;
            peak_mag_q   <= peak_mag_d;
            peak_valid_q <= peak_valid_d;
            overrun_q    <= overrun_d;
        end
    end

    // Frame storage is only observable through the gated outputs, so it needs no reset.
    always_ff @(posedge i_clk) begin
        if (capture) begin
            for (int k = 0; k < 32; k++) begin
                re_buf_q[k] <= i_re_bus[k*WORD_SIZE +: WORD_SIZE];
                im_buf_q[k] <= i_im_bus[k*WORD_SIZE +: WORD_SIZE];
            end
        end
    end

    assign o_bin_idx    = o_bin_valid ? idx_q : 5'd0;
    assign o_bin_re     = sel_re;
    assign o_bin_im     = sel_im;
    assign o_bin_mag    = mag;
    assign o_last       = o_bin_valid && (idx_q == 5'd31);
    assign o_busy       = (state_q != IDLE);
    assign o_peak_valid = peak_valid_q;
    assign o_peak_idx   = peak_idx_q;
    assign o_peak_mag   = peak_mag_q;
    assign o_overrun    = overrun_q;
    assign o_state_dbg  = state_q;

endmodule

// File: doc/fft32_out_streamer.md
FFT32_OUT_STREAMER -- requirements
Module: fft32_out_streamer

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 16, width of each signed real/imag word.
REQ-002 SHALL have parameter FRACTION, default 8, fixed-point fraction bits; passed through only, no arithmetic effect.
REQ-003 SHALL have port i_clk, input, 1, the single clock; all state on its rising edge.
REQ-004 SHALL have port i_rst, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port i_fft_done, input, 1, FFT32 cycle-done level from the upstream FFT32 block.
REQ-006 SHALL have port i_re_bus, input, 32*WORD_SIZE, bin k real part at bits [k*WORD_SIZE +: WORD_SIZE].
REQ-007 SHALL have port i_im_bus, input, 32*WORD_SIZE, bin k imaginary part, same packing.
REQ-008 SHALL have port i_bin_ready, input, 1, downstream ready.
REQ-009 SHALL have port o_bin_valid, output, 1, bin data valid.
REQ-010 SHALL have port o_bin_idx, output, 5, index of presented bin.
REQ-011 SHALL have ports o_bin_re and o_bin_im, output, WORD_SIZE each, presented bin value.
REQ-012 SHALL have port o_bin_mag, output, WORD_SIZE+1, unsigned |re|+|im|.
REQ-013 SHALL have port o_last, output, 1, high with bin 31.
REQ-014 SHALL have port o_busy, output, 1, high outside IDLE.
REQ-015 SHALL have ports o_peak_valid (1), o_peak_idx (5), o_peak_mag (WORD_SIZE+1), outputs, peak-bin result.
REQ-016 SHALL have port o_overrun, output, 1, one-cycle pulse on a dropped frame.

Function
REQ-017 SHALL detect rising edge of i_fft_done (registered previous value); a level held high SHALL trigger once.
REQ-018 SHALL use states IDLE, STREAM, REPORT; IDLE->STREAM on edge; STREAM->REPORT on bin 31 handshake; REPORT->IDLE after one cycle.
REQ-019 On the edge in IDLE, SHALL capture both buses into a 32-entry internal frame buffer in that same cycle.
REQ-020 SHALL assert o_bin_valid with bin 0 exactly one cycle after the capturing edge.
REQ-021 A transfer SHALL occur when o_bin_valid and i_bin_ready are both high; index then advances by 1.
REQ-022 While o_bin_valid is high and i_bin_ready low, all o_bin_* and o_last SHALL hold stable.
REQ-023 Back-to-back transfers SHALL sustain one bin per cycle with i_bin_ready held high (32 cycles per frame).
REQ-024 o_bin_mag SHALL equal |re|+|im| of two's-complement inputs computed at WORD_SIZE+1 bits, no saturation (|-32768| = 32768).
REQ-025 Peak tracker SHALL update only on transfer when mag is strictly greater than current peak; ties keep lowest index; cleared to idx 0, mag 0 at frame start.
REQ-026 In REPORT, SHALL set o_peak_valid high; it SHALL stay high, with idx/mag held, until the next capturing edge clears it.
REQ-027 A rising edge of i_fft_done in STREAM or REPORT SHALL be ignored (buffer untouched) and pulse o_overrun for one cycle.
REQ-028 o_bin_valid SHALL be low in IDLE and REPORT; o_busy SHALL be high in STREAM and REPORT.

Reset
REQ-029 i_rst low SHALL immediately force IDLE, index 0, edge register 0, and all outputs 0, regardless of state.
REQ-030 After reset release, a i_fft_done already high SHALL count as a rising edge on the first clock.

Verification
REQ-031 Bins k=0..31 re=k*256, im=-k*256, ready held 1, one done edge -> bins 0..31 on 32 consecutive cycles, mag(k)=k*512, o_last with idx 31, peak idx 31 mag 15872.
REQ-032 Same frame, ready toggling 1-0-1-0 -> each bin held stable through ready-low cycles, 64 cycles total, identical data sequence.
REQ-033 Bins 3 and 9 both re=0x0500, im=0x0100, rest 0 -> peak idx 3, mag 0x0600.
REQ-034 Bin 0 re=0x8000, im=0x8000 -> o_bin_mag=0x10000.
REQ-035 Second done edge at bin 10 -> o_overrun one-cycle pulse, stream continues unchanged to bin 31.
REQ-036 i_rst low at bin 15 -> all outputs 0 asynchronously; after release and new edge, stream restarts at bin 0.
